fb_cmd_decoder: RTL and testbench

Parametrised command decoder between the COBS byte decoder and the video memories. It parses framed command streams into single-cycle write strobes for the pixel plane RAM and the palette RAM. Versus the previous fixed-width UART command path, it adds:
- configurable address and palette widths;
- a programmable address stride;
- a palette start index;
- a hardware fill command;
- explicit ready/valid back-pressure;
- error reporting.

---
 rtl/fb_cmd_pkg.sv | 28 ++
 rtl/fb_cmd_bytecollect.sv | 58 +++++
 rtl/fb_cmd_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_fb_cmd_decoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_cmd_pkg.sv
// Shared opcodes, parser states and sizing helper for the framebuffer command decoder.
package fb_cmd_pkg;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_DATA       = 3'd1;
    localparam logic [2:0] OP_SET_ADDR   = 3'd2;
    localparam logic [2:0] OP_SET_STRIDE = 3'd3;
    localparam logic [2:0] OP_PALETTE    = 3'd4;
    localparam logic [2:0] OP_FILL       = 3'd5;

    typedef enum logic [3:0] {
        S_CMD,
        S_DATA,
        S_ADDR,
        S_STRIDE,
        S_PAL_IDX,
        S_PAL,
        S_FILL_LEN,
        S_FILL_VAL,
        S_FILL_RUN,
        S_DISCARD
    } state_t;

    function automatic int bytes_for(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/fb_cmd_bytecollect.sv
// Little-endian multi-byte assembler; value is valid in the cycle done is high,
// combining the stored lower bytes with the byte being accepted.
module fb_cmd_bytecollect
    import fb_cmd_pkg::*;
#(
    parameter int NBYTES = 2,
    parameter int OUT_W  = NBYTES * 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    output logic             done,
    output logic [OUT_W-1:0] value
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [NBYTES*8-1:0]   data_reg, data_next, full;

    assign done = byte_en && (cnt_reg == CNT_W'(NBYTES - 1));

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = byte_en && (cnt_reg == CNT_W'(gi));
            assign full[gi*8 +: 8]      = lane_hit ? byte_data : data_reg[gi*8 +: 8];
            assign data_next[gi*8 +: 8] = full[gi*8 +: 8];
        end
        if (NBYTES * 8 > OUT_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^full[NBYTES*8-1:OUT_W];
        end
    endgenerate

    assign value = full[OUT_W-1:0];

    always_comb begin
        cnt_next = cnt_reg;
        if (clear)
            cnt_next = '0;
        else if (byte_en)
            cnt_next = done ? '0 : cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            data_reg <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            data_reg <= data_next;
        end
    end

endmodule

// File: rtl/fb_cmd_decoder.sv
// Framed command parser driving plane-RAM and palette-RAM write strobes.
// Hardware fill command is built only when FB_CMD_FILL_EN is defined.
module fb_cmd_decoder
    import fb_cmd_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int PAL_AW     = 6,
    parameter int PAL_W      = 12,
    parameter int FILL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_sof,
    output logic              in_ready,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              pal_we,
    output logic [PAL_AW-1:0] pal_addr,
    output logic [PAL_W-1:0]  pal_din,
    output logic              cmd_err,
    output logic              busy
);

    localparam int ADDR_BYTES = bytes_for(ADDR_W);
    localparam int PAL_BYTES  = bytes_for(PAL_W);

    state_t state_reg, state_next, state_eff;
    logic   accept, col_clear, op_is_err;

    logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
    logic [7:0]        stride_reg, stride_next;
    logic [PAL_AW-1:0] pal_ptr_reg, pal_ptr_next;

    logic              vram_we_reg, vram_we_next;
    logic [ADDR_W-1:0] vram_addr_reg, vram_addr_next;
    logic [7:0]        vram_din_reg, vram_din_next;
    logic              pal_we_reg, pal_we_next;
    logic [PAL_AW-1:0] pal_addr_reg, pal_addr_next;
    logic [PAL_W-1:0]  pal_din_reg, pal_din_next;
    logic              cmd_err_reg, cmd_err_next;

    logic              addr_done, pal_done;
    logic [ADDR_W-1:0] addr_value;
    logic [PAL_W-1:0]  pal_value;

    // Frame start overrides whatever the parser was doing, and the byte that
    // arrives with it is decoded as a command.
    assign state_eff = in_sof ? S_CMD : state_reg;
    assign accept    = in_valid && in_ready;
    assign col_clear = in_sof || (accept && state_eff == S_CMD);

    fb_cmd_bytecollect #(.NBYTES(ADDR_BYTES), .OUT_W(ADDR_W)) u_addr_col (
        .clk(clk), .rst(rst), .clear(col_clear),
        .byte_en(accept && state_eff == S_ADDR), .byte_data(in_data),
        .done(addr_done), .value(addr_value)
    );

    fb_cmd_bytecollect #(.NBYTES(PAL_BYTES), .OUT_W(PAL_W)) u_pal_col (
        .clk(clk), .rst(rst), .clear(col_clear),
        .byte_en(accept && state_eff == S_PAL), .byte_data(in_data),
        .done(pal_done), .value(pal_value)
    );

`ifdef FB_CMD_FILL_EN
    logic [FILL_CNT_W-1:0] fill_cnt_reg, fill_cnt_next, len_value;
    logic [7:0]            fill_val_reg, fill_val_next;
    logic                  busy_reg, busy_next, len_done, fill_fire;

    fb_cmd_bytecollect #(.NBYTES(FILL_CNT_W / 8), .OUT_W(FILL_CNT_W)) u_len_col (
        .clk(clk), .rst(rst), .clear(col_clear),
        .byte_en(accept && state_eff == S_FILL_LEN), .byte_data(in_data),
        .done(len_done), .value(len_value)
    );

    assign fill_fire = (state_eff == S_FILL_RUN);
    assign op_is_err = (in_data[2:0] > OP_FILL);
    assign in_ready  = (state_reg != S_FILL_RUN);
    assign busy      = busy_reg;
`else
    logic [FILL_CNT_W-1:0] unused_fill_cnt;
    assign unused_fill_cnt = '0;
    assign op_is_err = (in_data[2:0] > OP_PALETTE);
    assign in_ready  = 1'b1;
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= S_CMD;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_eff;
        if (accept) begin
            case (state_eff)
                S_CMD: begin
                    if (op_is_err)
                        state_next = S_DISCARD;
                    else begin
                        case (in_data[2:0])
                            OP_DATA:       state_next = S_DATA;
                            OP_SET_ADDR:   state_next = S_ADDR;
                            OP_SET_STRIDE: state_next = S_STRIDE;
                            OP_PALETTE:    state_next = S_PAL_IDX;
`ifdef FB_CMD_FILL_EN
                            OP_FILL:       state_next = S_FILL_LEN;
`endif
                            default:       state_next = S_CMD;
                        endcase
                    end
                end
                S_ADDR:    if (addr_done) state_next = S_CMD;
                S_STRIDE:  state_next = S_CMD;
                S_PAL_IDX: state_next = S_PAL;
`ifdef FB_CMD_FILL_EN
                S_FILL_LEN: if (len_done) state_next = S_FILL_VAL;
                S_FILL_VAL: state_next = (fill_cnt_reg == '0) ? S_CMD : S_FILL_RUN;
`endif
                default: ;
            endcase
        end
`ifdef FB_CMD_FILL_EN
        if (fill_fire && fill_cnt_reg == FILL_CNT_W'(1))
            state_next = S_CMD;
`endif
    end

    always_comb begin
        addr_ptr_next  = addr_ptr_reg;
        stride_next    = stride_reg;
        pal_ptr_next   = pal_ptr_reg;
        vram_we_next   = 1'b0;
        vram_addr_next = vram_addr_reg;
        vram_din_next  = vram_din_reg;
        pal_we_next    = 1'b0;
        pal_addr_next  = pal_addr_reg;
        pal_din_next   = pal_din_reg;
        cmd_err_next   = 1'b0;
`ifdef FB_CMD_FILL_EN
        fill_cnt_next  = fill_cnt_reg;
        fill_val_next  = fill_val_reg;
`endif
        if (accept) begin
            case (state_eff)
                S_CMD:     cmd_err_next = op_is_err;
                S_DATA: begin
                    vram_we_next   = 1'b1;
                    vram_addr_next = addr_ptr_reg;
                    vram_din_next  = in_data;
                    addr_ptr_next  = addr_ptr_reg + ADDR_W'(stride_reg);
                end
                S_ADDR:    if (addr_done) addr_ptr_next = addr_value;
                S_STRIDE:  stride_next = in_data;
                S_PAL_IDX: pal_ptr_next = in_data[PAL_AW-1:0];
                S_PAL: begin
                    if (pal_done) begin
                        pal_we_next   = 1'b1;
                        pal_addr_next = pal_ptr_reg;
                        pal_din_next  = pal_value;
                        pal_ptr_next  = pal_ptr_reg + PAL_AW'(1);
                    end
                end
`ifdef FB_CMD_FILL_EN
                S_FILL_LEN: if (len_done) fill_cnt_next = len_value;
                S_FILL_VAL: fill_val_next = in_data;
`endif
                default: ;
            endcase
        end
`ifdef FB_CMD_FILL_EN
        if (fill_fire) begin
            vram_we_next   = 1'b1;
            vram_addr_next = addr_ptr_reg;
            vram_din_next  = fill_val_reg;
            addr_ptr_next  = addr_ptr_reg + ADDR_W'(stride_reg);
            fill_cnt_next  = fill_cnt_reg - FILL_CNT_W'(1);
        end
        // Held through the final strobe so busy falls one cycle after it.
        busy_next = (state_next == S_FILL_RUN) || fill_fire;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_ptr_reg  <= '0;
            stride_reg    <= 8'd1;
            pal_ptr_reg   <= '0;
            vram_we_reg   <= 1'b0;
            vram_addr_reg <= '0;
            vram_din_reg  <= '0;
            pal_we_reg    <= 1'b0;
            pal_addr_reg  <= '0;
            pal_din_reg   <= '0;
            cmd_err_reg   <= 1'b0;
        end else begin
            addr_ptr_reg  <= addr_ptr_next;
            stride_reg    <= stride_next;
            pal_ptr_reg   <= pal_ptr_next;
            vram_we_reg   <= vram_we_next;
            vram_addr_reg <= vram_addr_next;
            vram_din_reg  <= vram_din_next;
            pal_we_reg    <= pal_we_next;
            pal_addr_reg  <= pal_addr_next;
            pal_din_reg   <= pal_din_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

`ifdef FB_CMD_FILL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt_reg <= '0;
            fill_val_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            fill_cnt_reg <= fill_cnt_next;
            fill_val_reg <= fill_val_next;
            busy_reg     <= busy_next;
        end
    end
`endif

    assign vram_we   = vram_we_reg;
    assign vram_addr = vram_addr_reg;
    assign vram_din  = vram_din_reg;
    assign pal_we    = pal_we_reg;
    assign pal_addr  = pal_addr_reg;
    assign pal_din   = pal_din_reg;
    assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_fb_cmd_decoder.sv
// Bench for fb_cmd_decoder: directed scenarios plus random frames against a byte-stream parser model.
module tb_fb_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_din;
    logic        pal_we;
    logic [5:0]  pal_addr;
    logic [11:0] pal_din;
    logic        cmd_err;
    logic        busy;

    fb_cmd_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_ready(in_ready),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_din(pal_din),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int a; int d; } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exp_v[$], obs_v[$], exp_p[$], obs_p[$];
    int   exp_e[$], obs_e[$];
    logic [7:0] fb[$];

    // Reference parser: interprets the byte stream directly with integer arithmetic.
    localparam int M_CMD = 0, M_DATA = 1, M_ADDR = 2, M_STRIDE = 3, M_PIDX = 4,
                   M_PAL = 5, M_DISC = 6, M_FLEN = 7, M_FVAL = 8;
    int m_mode, m_addr, m_stride, m_pal, m_acc, m_n, m_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vram_we) obs_v.push_back('{cyc, int'(vram_addr), int'(vram_din)});
        if (pal_we)  obs_p.push_back('{cyc, int'(pal_addr), int'(pal_din)});
        if (cmd_err) obs_e.push_back(cyc);
        if (vram_we || pal_we) check("we_exclusive", {31'd0, vram_we & pal_we}, 0);
    end

    task automatic model_reset();
        m_mode = M_CMD; m_addr = 0; m_stride = 1; m_pal = 0; m_acc = 0; m_n = 0; m_len = 0;
    endtask

    task automatic model_byte(input bit s, input int b, input int c);
        if (s) begin m_mode = M_CMD; m_acc = 0; m_n = 0; end
        case (m_mode)
            M_CMD: begin
                m_acc = 0; m_n = 0;
                case (b % 8)
                    0: ;
                    1: m_mode = M_DATA;
                    2: m_mode = M_ADDR;
                    3: m_mode = M_STRIDE;
                    4: m_mode = M_PIDX;
                    5: begin
`ifdef FB_CMD_FILL_EN
                        m_mode = M_FLEN;
`else
                        exp_e.push_back(c + 1); m_mode = M_DISC;
`endif
                    end
                    default: begin exp_e.push_back(c + 1); m_mode = M_DISC; end
                endcase
            end
            M_DATA: begin
                exp_v.push_back('{c + 1, m_addr, b});
                m_addr = (m_addr + m_stride) % 65536;
            end
            M_ADDR: begin
                m_acc += b << (8 * m_n); m_n++;
                if (m_n == 2) begin m_addr = m_acc % 65536; m_mode = M_CMD; end
            end
            M_STRIDE: begin m_stride = b; m_mode = M_CMD; end
            M_PIDX: begin m_pal = b % 64; m_acc = 0; m_n = 0; m_mode = M_PAL; end
            M_PAL: begin
                m_acc += b << (8 * m_n); m_n++;
                if (m_n == 2) begin
                    exp_p.push_back('{c + 1, m_pal, m_acc % 4096});
                    m_pal = (m_pal + 1) % 64; m_acc = 0; m_n = 0;
                end
            end
            M_FLEN: begin
                m_acc += b << (8 * m_n); m_n++;
                if (m_n == 2) begin m_len = m_acc; m_mode = M_FVAL; end
            end
            M_FVAL: begin
                for (int k = 0; k < m_len; k++) begin
                    exp_v.push_back('{c + 2 + k, m_addr, b});
                    m_addr = (m_addr + m_stride) % 65536;
                end
                m_mode = M_CMD;
            end
            default: ;
        endcase
    endtask

`ifdef FB_CMD_FILL_EN
    task automatic model_fill_cut(input int len, input int done);
        int base, start;
        base  = exp_v.size() - len;
        start = exp_v[base].a;
        while (exp_v.size() > base + done) void'(exp_v.pop_back());
        m_addr = (start + done * m_stride) % 65536;
    endtask
`endif

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit s, input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = b; in_sof = s;
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("ready_timeout", {31'd0, in_ready}, 1);
        model_byte(s, int'(b), cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(i == 0, bytes[i]);
    endtask

    task automatic finish_scn(input string tag);
        int n;
        idle(3);
        check({tag, "_vram_count"}, obs_v.size(), exp_v.size());
        n = (obs_v.size() < exp_v.size()) ? obs_v.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_vram_cycle"}, obs_v[i].cyc, exp_v[i].cyc);
            check({tag, "_vram_addr"},  obs_v[i].a,   exp_v[i].a);
            check({tag, "_vram_data"},  obs_v[i].d,   exp_v[i].d);
        end
        check({tag, "_pal_count"}, obs_p.size(), exp_p.size());
        n = (obs_p.size() < exp_p.size()) ? obs_p.size() : exp_p.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_pal_cycle"}, obs_p[i].cyc, exp_p[i].cyc);
            check({tag, "_pal_addr"},  obs_p[i].a,   exp_p[i].a);
            check({tag, "_pal_data"},  obs_p[i].d,   exp_p[i].d);
        end
        check({tag, "_err_count"}, obs_e.size(), exp_e.size());
        n = (obs_e.size() < exp_e.size()) ? obs_e.size() : exp_e.size();
        for (int i = 0; i < n; i++) check({tag, "_err_cycle"}, obs_e[i], exp_e[i]);
        $display("scenario %s: vram=%0d pal=%0d err=%0d", tag, obs_v.size(), obs_p.size(), obs_e.size());
        exp_v.delete(); obs_v.delete(); exp_p.delete(); obs_p.delete();
        exp_e.delete(); obs_e.delete();
    endtask

    task automatic expect_v(input string tag, input int idx, input int a, input int d);
        check({tag, "_present"}, {31'd0, obs_v.size() > idx}, 1);
        if (obs_v.size() > idx) begin
            check({tag, "_addr"}, obs_v[idx].a, a);
            check({tag, "_data"}, obs_v[idx].d, d);
        end
    endtask

    task automatic expect_p(input string tag, input int idx, input int a, input int d);
        check({tag, "_present"}, {31'd0, obs_p.size() > idx}, 1);
        if (obs_p.size() > idx) begin
            check({tag, "_addr"}, obs_p[idx].a, a);
            check({tag, "_data"}, obs_p[idx].d, d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(2);
        check("rst_vram_we",   {31'd0, vram_we}, 0);
        check("rst_vram_addr", {16'd0, vram_addr}, 0);
        check("rst_vram_din",  {24'd0, vram_din}, 0);
        check("rst_pal_we",    {31'd0, pal_we}, 0);
        check("rst_pal_din",   {20'd0, pal_din}, 0);
        check("rst_cmd_err",   {31'd0, cmd_err}, 0);
        check("rst_busy",      {31'd0, busy}, 0);
        check("rst_in_ready",  {31'd0, in_ready}, 1);
        rst = 1'b1;

        // Addressed burst
        send_frame('{8'h02, 8'h34, 8'h12, 8'h01, 8'hAA, 8'hBB, 8'hCC});
        idle(2);
        expect_v("burst0", 0, 'h1234, 'hAA);
        expect_v("burst1", 1, 'h1235, 'hBB);
        expect_v("burst2", 2, 'h1236, 'hCC);
        finish_scn("burst");

        // Stride and address wrap
        send_frame('{8'h02, 8'hFE, 8'hFF, 8'h03, 8'h04, 8'h01, 8'h11, 8'h22});
        idle(2);
        expect_v("wrap0", 0, 'hFFFE, 'h11);
        expect_v("wrap1", 1, 'h0002, 'h22);
        finish_scn("wrap");

        // Palette with start index and index wrap
        send_frame('{8'h04, 8'h3F, 8'h21, 8'h0A, 8'h43, 8'h05});
        idle(2);
        expect_p("pal0", 0, 63, 'hA21);
        expect_p("pal1", 1, 0,  'h543);
        finish_scn("palette");
        send_frame('{8'h04, 8'h00, 8'h99});
        idle(2);
        check("pal_partial_none", obs_p.size(), 0);
        finish_scn("pal_partial");

        // Aborted SET_ADDR keeps the old pointer (0x0006 after the wrap burst)
        send_frame('{8'h02, 8'h10});
        send_frame('{8'h01, 8'h55});
        idle(2);
        expect_v("abort_addr", 0, 'h0006, 'h55);
        finish_scn("abort_addr");

        // Undefined opcode
        send_frame('{8'h07, 8'h01, 8'hAA});
        idle(2);
        check("err_pulses", obs_e.size(), 1);
        check("err_no_write", obs_v.size(), 0);
        finish_scn("error");
        send_frame('{8'h01, 8'hAA});
        idle(2);
        expect_v("after_err", 0, 'h000A, 'hAA);
        finish_scn("after_err");

`ifdef FB_CMD_FILL_EN
        send_frame('{8'h02, 8'h00, 8'h01});
        send_frame('{8'h03, 8'h01});
        send_frame('{8'h05, 8'h03, 8'h00, 8'h7E});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("fill_ready_low", {31'd0, in_ready}, 0);
            check("fill_busy_high", {31'd0, busy}, 1);
        end
        @(negedge clk);
        check("fill_busy_last", {31'd0, busy}, 1);
        @(negedge clk);
        check("fill_busy_drop", {31'd0, busy}, 0);
        expect_v("fill0", 0, 'h0100, 'h7E);
        expect_v("fill2", 2, 'h0102, 'h7E);
        finish_scn("fill");

        send_frame('{8'h05, 8'h05, 8'h00, 8'h7E});
        @(negedge clk);
        @(negedge clk);
        in_sof = 1'b1;
        @(posedge clk);
        #1;
        in_sof = 1'b0;
        model_fill_cut(5, 1);
        idle(2);
        check("fill_abort_busy", {31'd0, busy}, 0);
        finish_scn("fill_abort");

        send_frame('{8'h05, 8'h00, 8'h00, 8'h55});
        send_frame('{8'h01, 8'h66});
        finish_scn("fill_zero");

        send_frame('{8'h05, 8'h0A, 8'h00, 8'h3C});
        idle(3);
        #2;
        rst = 1'b0;
        model_fill_cut(10, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_fill_we", {31'd0, vram_we}, 0);
            check("rst_fill_ready", {31'd0, in_ready}, 1);
            check("rst_fill_busy", {31'd0, busy}, 0);
        end
        rst = 1'b1;
        model_reset();
        finish_scn("fill_reset");
`else
        send_frame('{8'h05, 8'h01, 8'hAA});
        check("nofill_busy", {31'd0, busy}, 0);
        check("nofill_ready", {31'd0, in_ready}, 1);
        finish_scn("nofill_op5");
`endif

        // Random frames
        for (int f = 0; f < 60; f++) begin
            int np, t, n, op;
            fb.delete();
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) begin
                case ($urandom_range(0, 2))
                    0: fb.push_back({5'($urandom), 3'd0});
                    1: begin
                        fb.push_back({5'($urandom), 3'd2});
                        fb.push_back(8'($urandom));
                        fb.push_back(8'($urandom));
                    end
                    default: begin
                        fb.push_back({5'($urandom), 3'd3});
                        fb.push_back(($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
                    end
                endcase
            end
            t = $urandom_range(0, 4);
            n = $urandom_range(1, 8);
            if (t <= 1) begin
                fb.push_back({5'($urandom), 3'd1});
                for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
            end else if (t <= 3) begin
                fb.push_back({5'($urandom), 3'd4});
                fb.push_back(8'($urandom));
                for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
            end else begin
`ifdef FB_CMD_FILL_EN
                op = $urandom_range(6, 7);
`else
                op = $urandom_range(5, 7);
`endif
                fb.push_back({5'($urandom), 3'(op)});
                fb.push_back(8'($urandom));
                fb.push_back(8'h01);
            end
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, fb.size());
                while (fb.size() > n) void'(fb.pop_back());
            end
            foreach (fb[i]) begin
                send(i == 0, fb[i]);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if (f % 10 == 9) finish_scn("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
